// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: loader states,
// word packing constants and a small address helper.
package instr_mem_loader_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_COLLECT = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } loader_state_t;

  // Byte address of word 'idx' in a word-addressed memory starting at 'base'.
  function automatic logic [31:0] word_to_byte_addr(input logic [31:0] base,
                                                    input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte stream input plus instruction memory write port of the loader.
// The master is the host side (byte source / memory observer), the slave
// is the loader itself.
interface instr_mem_loader_if;
  import instr_mem_loader_pkg::*;

  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [31:0]           mem_address;
  logic                  mem_write;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_data_in,
    input  mem_address,
    input  mem_write
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_data_in,
    output mem_address,
    output mem_write
  );

endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. The three earlier
// bytes of a word are kept in a shift register; 'word' merges them with the
// byte currently on the bus, so it holds the complete word in the same cycle
// the fourth byte is accepted (flagged by word_full).
module byte_packer
  import instr_mem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_full
);

  logic [1:0]            byte_cnt;
  logic [WORD_WIDTH-9:0] shift_q;

  assign word      = {byte_in, shift_q};
  assign word_full = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Shift each accepted byte in from the top; clear wins so a length byte is never packed.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (accept) begin
      byte_cnt <= byte_cnt + 2'd1;
      shift_q  <= word[WORD_WIDTH-1:8];
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Writer side of the instruction memory: takes a length byte followed by
// 4*N data bytes, writes N little-endian words starting at BASE_ADDR and
// keeps the CPU held until an image has been loaded without error.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int          DATA_SIZE    = 32,
  parameter int          ADDRESS_SIZE = 5,
  parameter logic [31:0] BASE_ADDR    = 32'h0
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  instr_mem_loader_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_hold
);

  // One extra index bit so a full-depth image can count all the way to 2**ADDRESS_SIZE.
  localparam int          IDX_W = ADDRESS_SIZE + 1;
  localparam logic [31:0] DEPTH = 32'd1 << ADDRESS_SIZE;

  loader_state_t          state;
  logic                   byte_ready_q;
  logic                   mem_write_q;
  logic [DATA_SIZE-1:0]   mem_data_q;
  logic [31:0]            mem_addr_q;
  logic [IDX_W-1:0]       idx;
  logic [LEN_WIDTH-1:0]   len_q;

  logic                   accept;
  logic                   pack_clear;
  logic                   word_full;
  logic [WORD_WIDTH-1:0]  packed_word;
  logic [IDX_W-1:0]       idx_next;
  logic                   last_word;

  assign accept     = bus.byte_valid && byte_ready_q;
  assign pack_clear = (state == ST_LEN) || (state == ST_WRITE);
  assign idx_next   = idx + 1'b1;
  assign last_word  = (32'(idx_next) == 32'(len_q));

  assign bus.byte_ready  = byte_ready_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_data_in = mem_data_q;
  assign bus.mem_address = mem_addr_q;

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pack_clear),
    .accept    (accept),
    .byte_in   (bus.byte_in),
    .word      (packed_word),
    .word_full (word_full)
  );

  // Load sequencer: all outputs are registered and set on the edge that enters each state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      byte_ready_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_data_q   <= '0;
      mem_addr_q   <= BASE_ADDR;
      idx          <= '0;
      len_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
    end else begin
      mem_write_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_LEN;
            byte_ready_q <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            idx          <= '0;
          end
        end
        ST_LEN: begin
          if (accept) begin
            if (bus.byte_in == 8'd0) begin
              state        <= ST_DONE;
              byte_ready_q <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              cpu_hold     <= 1'b0;
            end else if (32'(bus.byte_in) > DEPTH) begin
              state        <= ST_DONE;
              byte_ready_q <= 1'b0;
              busy         <= 1'b0;
              done         <= 1'b1;
              error        <= 1'b1;
            end else begin
              len_q <= bus.byte_in;
              state <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (word_full) begin
            state        <= ST_WRITE;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b1;
            mem_data_q   <= packed_word;
            mem_addr_q   <= word_to_byte_addr(BASE_ADDR, 32'(idx));
          end
        end
        ST_WRITE: begin
          idx <= idx_next;
          if (last_word) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state        <= ST_COLLECT;
            byte_ready_q <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          byte_ready_q <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
